// File: rtl/core_pkg.sv
// Shared types and constants for the execute-stage micro-op sequencer:
// FSM states, op kinds, ALU function codes, register indices and control decode.
package core_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_EXEC  = 2'b01,
        S_LWB   = 2'b10,
        S_REDIR = 2'b11
    } state_e;

    typedef enum logic [1:0] {
        K_ALU   = 2'b00,
        K_LOAD  = 2'b01,
        K_STORE = 2'b10,
        K_NOP   = 2'b11
    } kind_e;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0010;
    localparam logic [3:0] ALU_LDA = 4'b0111;

    localparam logic [2:0] REG_ZERO  = 3'd0;
    localparam logic [2:0] REG_FLAGS = 3'd2;
    localparam logic [2:0] REG_PC    = 3'd3;

    typedef struct packed {
        kind_e       kind;
        logic [3:0]  alu_f;
        logic [2:0]  a;
        logic [2:0]  b;
        logic [2:0]  d;
        logic [15:0] imm;
        logic        sel_imm;
        logic        set_flags;
        logic        carry_mask;
    } op_t;

    typedef struct packed {
        logic [3:0]  alu_f;
        logic [2:0]  a_idx;
        logic [2:0]  b_idx;
        logic [2:0]  d_idx;
        logic [15:0] t16;
        logic        sel_inp;
        logic        carry_mask;
        logic        wr_reg;
        logic        wr_flags;
        logic        mem_req;
        logic        mem_we;
        logic        redirect;
        logic        busy;
    } ctl_t;

    // Control word the sequencer presents while sitting in state st with op latched.
    function automatic ctl_t ctl_decode(input state_e      st,
                                        input op_t         op,
                                        input logic [15:0] ld,
                                        input logic [2:0]  zero_reg);
        ctl_t c;
        c = '0;
        case (st)
            S_EXEC: begin
                c.busy = 1'b1;
                case (op.kind)
                    K_ALU: begin
                        c.alu_f      = op.alu_f;
                        c.a_idx      = op.a;
                        c.b_idx      = op.b;
                        c.d_idx      = op.d;
                        c.t16        = op.imm;
                        c.sel_inp    = op.sel_imm;
                        c.carry_mask = op.carry_mask;
                        c.wr_reg     = 1'b1;
                        c.wr_flags   = op.set_flags;
                    end
                    K_LOAD, K_STORE: begin
                        // Datapath forms base+offset on mar_val; source reg appears on mem_data.
                        c.alu_f   = ALU_LDA;
                        c.a_idx   = op.a;
                        c.b_idx   = op.b;
                        c.t16     = op.imm;
                        c.sel_inp = 1'b1;
                        c.mem_req = 1'b1;
                        c.mem_we  = (op.kind == K_STORE);
                    end
                    default: c.busy = 1'b1;
                endcase
            end
            S_LWB: begin
                c.busy       = 1'b1;
                c.alu_f      = ALU_ADD;
                c.a_idx      = zero_reg;
                c.sel_inp    = 1'b1;
                c.carry_mask = 1'b1;
                c.t16        = ld;
                c.d_idx      = op.d;
                c.wr_reg     = 1'b1;
                c.wr_flags   = op.set_flags;
            end
            S_REDIR: begin
                c.busy     = 1'b1;
                c.redirect = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/alu_seq.sv
// Micro-op sequencer for the register-file/ALU execute stage: accepts decoded ops,
// drives datapath controls, runs the memory handshake and inserts PC-write bubbles.
module alu_seq
    import core_pkg::*;
#(
    parameter logic [2:0] ZERO_REG  = REG_ZERO,
    parameter logic [2:0] FLAGS_REG = REG_FLAGS,
    parameter logic [2:0] PC_REG    = REG_PC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic [1:0]  op_kind,
    input  logic [3:0]  op_alu_f,
    input  logic [2:0]  op_a,
    input  logic [2:0]  op_b,
    input  logic [2:0]  op_d,
    input  logic [15:0] op_imm,
    input  logic        op_sel_imm,
    input  logic        op_set_flags,
    input  logic        op_carry_mask,
    output logic [3:0]  alu_f,
    output logic [2:0]  a_idx,
    output logic [2:0]  b_idx,
    output logic [2:0]  d_idx,
    output logic [15:0] t16,
    output logic        sel_inp,
    output logic        carry_mask,
    output logic        wr_reg,
    output logic        wr_flags,
    input  logic [15:0] mar_val,
    input  logic [15:0] mem_data,
    input  logic        wr_pc,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack,
    output logic        redirect,
    output logic        busy
);

    state_e      r_state;
    op_t         r_op;
    logic [15:0] r_ld;
    ctl_t        r_ctl;

    op_t         w_in_op;
    logic        w_ready;
    logic        w_accept;
    logic        w_unused_params;

    // FLAGS/PC indices are resolved by the datapath; kept so all instances share one parameter set.
    assign w_unused_params = ^{FLAGS_REG, PC_REG};

    assign w_in_op = '{kind:       kind_e'(op_kind),
                       alu_f:      op_alu_f,
                       a:          op_a,
                       b:          op_b,
                       d:          op_d,
                       imm:        op_imm,
                       sel_imm:    op_sel_imm,
                       set_flags:  op_set_flags,
                       carry_mask: op_carry_mask};

    // Ready: idle, or an ALU op finishing this cycle without touching the PC.
    always_comb begin
        w_ready = 1'b0;
        if (rst) begin
            w_ready = 1'b0;
        end else begin
            case (r_state)
                S_IDLE:  w_ready = 1'b1;
                S_EXEC:  w_ready = (r_op.kind == K_ALU) && !wr_pc;
                default: w_ready = 1'b0;
            endcase
        end
    end

    assign op_ready = w_ready;
    assign w_accept = op_valid & w_ready;

    // Sequencer FSM; the control word is registered alongside each state change.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_op    <= '0;
            r_ld    <= 16'h0000;
            r_ctl   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state <= S_EXEC;
                        r_op    <= w_in_op;
                        r_ctl   <= ctl_decode(S_EXEC, w_in_op, r_ld, ZERO_REG);
                    end else begin
                        r_state <= S_IDLE;
                        r_ctl   <= '0;
                    end
                end
                S_EXEC: begin
                    case (r_op.kind)
                        K_ALU: begin
                            if (wr_pc) begin
                                r_state <= S_REDIR;
                                r_ctl   <= ctl_decode(S_REDIR, r_op, r_ld, ZERO_REG);
                            end else if (w_accept) begin
                                r_state <= S_EXEC;
                                r_op    <= w_in_op;
                                r_ctl   <= ctl_decode(S_EXEC, w_in_op, r_ld, ZERO_REG);
                            end else begin
                                r_state <= S_IDLE;
                                r_ctl   <= '0;
                            end
                        end
                        K_STORE: begin
                            if (mem_ack) begin
                                r_state <= S_IDLE;
                                r_ctl   <= '0;
                            end else begin
                                r_state <= S_EXEC;
                            end
                        end
                        K_LOAD: begin
                            if (mem_ack) begin
                                r_state <= S_LWB;
                                r_ld    <= mem_rdata;
                                r_ctl   <= ctl_decode(S_LWB, r_op, mem_rdata, ZERO_REG);
                            end else begin
                                r_state <= S_EXEC;
                            end
                        end
                        default: begin
                            r_state <= S_IDLE;
                            r_ctl   <= '0;
                        end
                    endcase
                end
                S_LWB: begin
                    if (wr_pc) begin
                        r_state <= S_REDIR;
                        r_ctl   <= ctl_decode(S_REDIR, r_op, r_ld, ZERO_REG);
                    end else begin
                        r_state <= S_IDLE;
                        r_ctl   <= '0;
                    end
                end
                S_REDIR: begin
                    r_state <= S_IDLE;
                    r_ctl   <= '0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ctl   <= '0;
                end
            endcase
        end
    end

    assign alu_f      = r_ctl.alu_f;
    assign a_idx      = r_ctl.a_idx;
    assign b_idx      = r_ctl.b_idx;
    assign d_idx      = r_ctl.d_idx;
    assign t16        = r_ctl.t16;
    assign sel_inp    = r_ctl.sel_inp;
    assign carry_mask = r_ctl.carry_mask;
    assign wr_reg     = r_ctl.wr_reg;
    assign wr_flags   = r_ctl.wr_flags;
    assign mem_req    = r_ctl.mem_req;
    assign mem_we     = r_ctl.mem_we;
    assign redirect   = r_ctl.redirect;
    assign busy       = r_ctl.busy;

    // Address and write data come straight from the datapath while a request is open.
    assign mem_addr  = r_ctl.mem_req ? mar_val  : 16'h0000;
    assign mem_wdata = r_ctl.mem_req ? mem_data : 16'h0000;

endmodule

// File: doc/alu_seq.md
# alu_seq

Micro-op sequencer for the core's register-file/ALU execute stage. It accepts decoded micro-ops from the decoder over a valid/ready handshake and drives the execute datapath's function, index, write-enable and immediate controls. It also runs the 16-bit memory handshake for loads and stores, and inserts a redirect bubble whenever an op writes the PC register.

## Interface
Parameters:
- `ZERO_REG`, 3'd0: register index that reads zero by ISA convention; used as the base for load writeback.
- `FLAGS_REG`, 3'd2: index of the status register.
- `PC_REG`, 3'd3: index of the PC register.

Ports:
- `clk` in 1: sole clock.
- `rst` in 1: reset, synchronous, active-high.
- `op_valid` in 1, `op_ready` out 1: micro-op handshake.
- `op_kind` in 2: 00 ALU, 01 LOAD, 10 STORE, 11 NOP.
- `op_alu_f` in 4: ALU function code.
- `op_a`, `op_b`, `op_d` in 3 each: register indices.
- `op_imm` in 16: immediate value or address offset.
- `op_sel_imm` in 1: ALU second operand = immediate.
- `op_set_flags` in 1: update the low flags.
- `op_carry_mask` in 1: force carry-in to 0.
- `alu_f` out 4, `a_idx`/`b_idx`/`d_idx` out 3, `t16` out 16, `sel_inp` out 1, `carry_mask` out 1, `wr_reg` out 1, `wr_flags` out 1: datapath controls.
- `mar_val` in 16, `mem_data` in 16, `wr_pc` in 1: returned from the datapath.
- `mem_req` out 1, `mem_we` out 1, `mem_addr` out 16, `mem_wdata` out 16, `mem_rdata` in 16, `mem_ack` in 1: memory port.
- `redirect` out 1: one-cycle pulse after a PC write; fetch restarts.
- `busy` out 1: state is not IDLE.

## Operation
- States are IDLE, EXEC, LWB and REDIR.
- An op is accepted on a clock edge where `op_valid & op_ready`. Accepted fields are latched into an op register.
- IDLE:
  - `op_ready`=1.
  - On accept, go to EXEC; otherwise stay in IDLE.
- EXEC, ALU op:
  - Drive `alu_f`, `a_idx`, `b_idx`, `d_idx`, `t16`=imm, `sel_inp`, `carry_mask` from the latch.
  - `wr_reg`=1, `wr_flags`=`op_set_flags`.
  - If `wr_pc`, go to REDIR with `op_ready`=0.
  - Otherwise `op_ready`=1: on accept stay in EXEC with the new op; else go to IDLE.
- EXEC, STORE:
  - `a_idx`=base, `t16`=imm, `b_idx`=source.
  - `mem_req`=1, `mem_we`=1, `mem_addr`=`mar_val`, `mem_wdata`=`mem_data`.
  - `wr_reg`=0, `wr_flags`=0.
  - Hold until `mem_ack`, then go to IDLE.
- EXEC, LOAD:
  - Same as STORE but with `mem_we`=0.
  - On `mem_ack`, capture `mem_rdata` into the load register and go to LWB.
- LWB:
  - `alu_f`=0000 (ADD), `a_idx`=`ZERO_REG`, `sel_inp`=1, `carry_mask`=1, `t16`=load register, `d_idx`=`op_d`.
  - `wr_reg`=1, `wr_flags`=`op_set_flags`.
  - If `wr_pc`, go to REDIR; else go to IDLE.
- NOP: EXEC drives no writes, then returns to IDLE.
- REDIR:
  - `redirect`=1 for exactly one cycle.
  - `op_ready`=0, no writes.
  - Next state is IDLE.
- Outside EXEC and LWB, `wr_reg`, `wr_flags`, `mem_req` and `mem_we` are 0, and the datapath controls are 0.

## Timing
- Reset: state IDLE, op and load registers cleared.
- Reset values of outputs:
  - Every datapath control is 0.
  - `mem_req`, `mem_we`, `mem_addr`, `mem_wdata`, `redirect`, `busy` are 0.
  - `op_ready`=0 while `rst` is high.
- Reset mid-operation aborts immediately:
  - `mem_req` drops the following cycle.
  - No register write occurs.
  - A late `mem_ack` is ignored.
- ALU latency: op accepted at edge N, executes in cycle N+1, register written at edge N+2. Sustained throughput is 1 op per cycle.
- Memory handshake:
  - `mem_req` and `mem_addr`/`mem_wdata` stay stable until the ack.
  - An ack in the first EXEC cycle completes the access that cycle (2-cycle store, 3-cycle load).
  - Any `mem_ack` outside EXEC is ignored.
- `op_ready` is combinational from state and `wr_pc`. `op_valid` must not depend on `op_ready`.
- Flags write when the destination is the status register: the datapath gives `wr_flags` priority. The sequencer drives both signals unchanged.

## Structure
- Shared `core_pkg`:
  - state enum.
  - `op_kind` codes.
  - ALU function codes ADD=0000, SUB=0010, LDA=0111.
  - register index constants ZERO/FLAGS/PC.
- Sub-modules: none. This is a single FSM plus the op and load latches.

## Test plan
- ALU back-to-back: ADD r1=r4+r5, then SUB r6=r1-#3, driven on consecutive cycles. `op_ready` stays 1, `wr_reg` is high on 2 consecutive cycles, and `d_idx` is 1 then 6.
- Store with a 2-cycle wait: base r4, imm 0x0010, ack on the 3rd EXEC cycle. `mem_req`=`mem_we`=1 for 3 cycles, `mem_addr`=`mar_val` throughout, no `wr_reg`.
- Load with immediate ack, `mem_rdata`=0xBEEF, d=r5. In LWB: `alu_f`=0000, `a_idx`=0, `sel_inp`=1, `carry_mask`=1, `t16`=0xBEEF, `wr_reg`=1. Returns to IDLE one cycle later.
- ALU op with d=3 (PC). `wr_pc` is seen, `redirect` pulses for one cycle, and `op_ready`=0 in both that cycle and the REDIR cycle.
- `rst` asserted mid-load with `mem_req` high, and `mem_ack` asserted the cycle after. `mem_req`=0, no `wr_reg`, state IDLE, `busy`=0.
- NOP, then a load with `op_set_flags`=1. The NOP gives no writes. The load's LWB cycle has `wr_flags`=1.
